// File: rtl/ap_job_sequencer.sv
// Runs one associative-processor job: load operand banks A and B, fire the compute
// command, wait for the completion irq, then stream the result bank out.
module ap_job_sequencer #(
    parameter int unsigned WORD_SIZE      = 8,
    parameter int unsigned CELL_QUANT     = 512,
    parameter int unsigned ADDR_W         = $clog2(CELL_QUANT + 1),
    parameter int unsigned RES_BANK       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           cmd_in,
    input  logic                 dir_in,
    input  logic [ADDR_W-1:0]    len,
    output logic                 busy,
    output logic                 done,
    output logic                 err_len,
    output logic                 err_timeout,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_SIZE-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_SIZE-1:0] m_data,
    output logic [ADDR_W-1:0]    ap_addr,
    output logic [WORD_SIZE-1:0] ap_data,
    output logic [2:0]           ap_cmd,
    output logic [1:0]           ap_sel_col,
    output logic                 ap_sel_internal_col,
    output logic                 ap_mode,
    output logic                 ap_op_direction,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    input  logic [WORD_SIZE-1:0] ap_data_in,
    input  logic                 ap_state_irq
);

    localparam int unsigned TMO_W = 32;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT_IRQ,
        S_READ_REQ,
        S_READ_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [ADDR_W-1:0]    r_idx, w_idx_nxt;
    logic [ADDR_W-1:0]    r_len, w_len_nxt;
    logic [2:0]           r_cmd, w_cmd_nxt;
    logic                 r_dir, w_dir_nxt;
    logic [TMO_W-1:0]     r_tmo, w_tmo_nxt;
    logic [WORD_SIZE-1:0] r_mdata, w_mdata_nxt;
    logic [1:0]           r_sel_col;
    logic                 w_last;
    logic                 w_len_bad;
    logic                 w_tmo_hit;

    // len-1 compare keeps len==CELL_QUANT from needing an extra index bit
    assign w_last    = (r_idx == r_len - ADDR_W'(1));
    assign w_len_bad = (len == '0) || (32'(len) > CELL_QUANT);
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    assign m_data              = r_mdata;
    assign ap_sel_internal_col = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_len     <= '0;
            r_cmd     <= '0;
            r_dir     <= 1'b0;
            r_tmo     <= '0;
            r_mdata   <= '0;
            r_sel_col <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_len     <= w_len_nxt;
            r_cmd     <= w_cmd_nxt;
            r_dir     <= w_dir_nxt;
            r_tmo     <= w_tmo_nxt;
            r_mdata   <= w_mdata_nxt;
            r_sel_col <= ap_sel_col;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_len_nxt       = r_len;
        w_cmd_nxt       = r_cmd;
        w_dir_nxt       = r_dir;
        w_tmo_nxt       = r_tmo;
        w_mdata_nxt     = r_mdata;
        busy            = (r_state != S_IDLE);
        done            = 1'b0;
        err_len         = 1'b0;
        err_timeout     = 1'b0;
        s_ready         = 1'b0;
        m_valid         = 1'b0;
        ap_addr         = '0;
        ap_data         = '0;
        ap_cmd          = '0;
        ap_sel_col      = r_sel_col;
        ap_mode         = 1'b0;
        ap_op_direction = 1'b0;
        ap_write_en     = 1'b0;
        ap_read_en      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cmd_nxt = cmd_in;
                    w_dir_nxt = dir_in;
                    w_len_nxt = len;
                    if (w_len_bad) begin
                        err_len = 1'b1;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                s_ready    = 1'b1;
                ap_sel_col = (r_state == S_LOAD_A) ? 2'd0 : 2'd1;
                if (s_valid) begin
                    ap_write_en = 1'b1;
                    ap_addr     = r_idx;
                    ap_data     = s_data;
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (r_state == S_LOAD_A) ? S_LOAD_B : S_START;
                    end else begin
                        w_idx_nxt = r_idx + ADDR_W'(1);
                    end
                end
            end
            S_START: begin
                ap_mode         = 1'b1;
                ap_cmd          = r_cmd;
                ap_op_direction = r_dir;
                w_tmo_nxt       = '0;
                w_state_nxt     = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                ap_mode         = 1'b1;
                ap_cmd          = r_cmd;
                ap_op_direction = r_dir;
                // a completion seen on the timeout cycle still counts as success
                if (ap_state_irq) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_READ_REQ;
                end else if (w_tmo_hit) begin
                    err_timeout = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_READ_REQ: begin
                ap_read_en  = 1'b1;
                ap_sel_col  = 2'(RES_BANK);
                ap_addr     = r_idx;
                w_state_nxt = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                w_mdata_nxt = ap_data_in;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + ADDR_W'(1);
                        w_state_nxt = S_READ_REQ;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ap_job_sequencer.sv
// Job-level bench for ap_job_sequencer: a table of jobs plus random jobs, an AP memory
// model, an event logger and a second instance with a short timeout.
module tb_ap_job_sequencer;

    localparam int unsigned AW = 10;

    typedef struct {
        int         len;
        logic [2:0] cmd;
        logic       dir;
        int         irq_dly;
        int         stall_word;
        int         stall_len;
        logic       fixed_ops;
        logic       rnd_ready;
        logic       exp_err_len;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, dir_in, s_valid, m_ready, ap_state_irq;
    logic [2:0]    cmd_in;
    logic [AW-1:0] len;
    logic [7:0]    s_data, ap_data_in;
    logic          busy, done, err_len, err_timeout, s_ready, m_valid;
    logic [7:0]    m_data, ap_data;
    logic [AW-1:0] ap_addr;
    logic [2:0]    ap_cmd;
    logic [1:0]    ap_sel_col;
    logic          ap_sel_internal_col, ap_mode, ap_op_direction, ap_write_en, ap_read_en;

    logic          t_start, t_dir_in, t_s_valid, t_m_ready, t_irq;
    logic [2:0]    t_cmd_in;
    logic [AW-1:0] t_len;
    logic [7:0]    t_s_data, t_ap_data_in;
    logic          t_busy, t_done, t_err_len, t_err_timeout, t_s_ready, t_m_valid;
    logic [7:0]    t_m_data, t_ap_data;
    logic [AW-1:0] t_ap_addr;
    logic [2:0]    t_ap_cmd;
    logic [1:0]    t_ap_sel_col;
    logic          t_ap_sel_internal_col, t_ap_mode, t_ap_op_direction, t_ap_write_en, t_ap_read_en;

    assign t_ap_data_in = 8'h5A;

    ap_job_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .cmd_in(cmd_in), .dir_in(dir_in), .len(len),
        .busy(busy), .done(done), .err_len(err_len), .err_timeout(err_timeout),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ap_addr(ap_addr), .ap_data(ap_data), .ap_cmd(ap_cmd), .ap_sel_col(ap_sel_col),
        .ap_sel_internal_col(ap_sel_internal_col), .ap_mode(ap_mode),
        .ap_op_direction(ap_op_direction), .ap_write_en(ap_write_en), .ap_read_en(ap_read_en),
        .ap_data_in(ap_data_in), .ap_state_irq(ap_state_irq)
    );

    ap_job_sequencer #(.TIMEOUT_CYCLES(16)) u_tmo (
        .clk(clk), .rst(rst), .start(t_start), .cmd_in(t_cmd_in), .dir_in(t_dir_in), .len(t_len),
        .busy(t_busy), .done(t_done), .err_len(t_err_len), .err_timeout(t_err_timeout),
        .s_valid(t_s_valid), .s_ready(t_s_ready), .s_data(t_s_data),
        .m_valid(t_m_valid), .m_ready(t_m_ready), .m_data(t_m_data),
        .ap_addr(t_ap_addr), .ap_data(t_ap_data), .ap_cmd(t_ap_cmd), .ap_sel_col(t_ap_sel_col),
        .ap_sel_internal_col(t_ap_sel_internal_col), .ap_mode(t_ap_mode),
        .ap_op_direction(t_ap_op_direction), .ap_write_en(t_ap_write_en), .ap_read_en(t_ap_read_en),
        .ap_data_in(t_ap_data_in), .ap_state_irq(t_irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AP model: two operand banks, result bank reads back A+B one cycle after read_en
    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:1023];
    always @(posedge clk) begin
        if (ap_write_en) begin
            if (ap_sel_col == 2'd0) mem_a[ap_addr] <= ap_data;
            else if (ap_sel_col == 2'd1) mem_b[ap_addr] <= ap_data;
        end
        if (ap_read_en)
            ap_data_in <= (ap_sel_col == 2'd2) ? 8'(mem_a[ap_addr] + mem_b[ap_addr]) : 8'hEE;
    end

    // Event logger and protocol invariants, sampled away from the active edge
    int         q_wr[$];
    int         q_rd[$];
    int         q_m[$];
    int         n_done, n_errlen, n_errt, n_mode, n_viol;
    logic       prev_stall, prev_mode, prev_dir;
    logic [7:0] prev_md;
    logic [2:0] prev_cmd;
    initial begin
        n_done = 0; n_errlen = 0; n_errt = 0; n_mode = 0; n_viol = 0;
        prev_stall = 1'b0; prev_mode = 1'b0; prev_dir = 1'b0; prev_md = '0; prev_cmd = '0;
    end
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_mode  = 1'b0;
        end else begin
            if (ap_write_en) begin
                q_wr.push_back(int'({ap_sel_col, ap_addr, ap_data}));
                if (!s_ready || !s_valid) n_viol++;
            end
            if (ap_read_en) q_rd.push_back(int'({ap_sel_col, ap_addr}));
            if (ap_write_en && ap_read_en) n_viol++;
            if (t_ap_write_en && t_ap_read_en) n_viol++;
            if (ap_sel_internal_col || t_ap_sel_internal_col) n_viol++;
            if (m_valid && m_ready) q_m.push_back(int'(m_data));
            if (prev_stall && (!m_valid || m_data != prev_md)) n_viol++;
            if (prev_mode && ap_mode && (ap_cmd != prev_cmd || ap_op_direction != prev_dir)) n_viol++;
            if (done) n_done++;
            if (err_len) n_errlen++;
            if (err_timeout) n_errt++;
            if (ap_mode) n_mode++;
            prev_stall = m_valid && !m_ready;
            prev_md    = m_data;
            prev_mode  = ap_mode;
            prev_cmd   = ap_cmd;
            prev_dir   = ap_op_direction;
        end
    end

    task automatic run_job(input vec_t v, input string tag);
        int   a[0:511];
        int   b[0:511];
        int   acc, cyc, got, stall_cnt;
        logic mr;
        q_wr.delete(); q_rd.delete(); q_m.delete();
        n_done = 0; n_errlen = 0; n_errt = 0; n_mode = 0;
        for (int i = 0; i < v.len && i < 512; i++) begin
            a[i] = v.fixed_ops ? i + 1  : int'($urandom_range(0, 255));
            b[i] = v.fixed_ops ? 10 + i : int'($urandom_range(0, 255));
        end
        start = 1'b1; cmd_in = v.cmd; dir_in = v.dir; len = AW'(v.len);
        @(negedge clk);
        chk({tag, " err_len"}, err_len, v.exp_err_len);
        chk({tag, " busy_at_start"}, busy, 0);
        tick();
        start = 1'b0;
        if (v.exp_err_len) begin
            repeat (4) tick();
            @(negedge clk);
            chk({tag, " busy_after_reject"}, busy, 0);
            chk({tag, " err_len_count"}, n_errlen, 1);
            chk({tag, " ap_activity"}, q_wr.size() + q_rd.size() + n_mode, 0);
            tick();
            return;
        end
        for (int i = 0; i < 2 * v.len; i++) begin
            s_valid = 1'b0;
            if (!v.fixed_ops) repeat ($urandom_range(0, 2)) tick();
            s_valid = 1'b1;
            s_data  = 8'((i < v.len) ? a[i] : b[i - v.len]);
            acc = 0; cyc = 0;
            while (acc == 0 && cyc < 20) begin
                @(negedge clk);
                acc = int'(s_ready);
                tick();
                cyc++;
            end
            if (acc == 0) chk({tag, " load_accept"}, 0, 1);
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk({tag, " start_mode"}, ap_mode, 1);
        chk({tag, " start_cmd"}, ap_cmd, v.cmd);
        chk({tag, " start_dir"}, ap_op_direction, v.dir);
        tick();
        repeat (v.irq_dly - 1) tick();
        ap_state_irq = 1'b1;
        @(negedge clk);
        chk({tag, " mode_at_irq"}, ap_mode, 1);
        tick();
        ap_state_irq = 1'b0;
        @(negedge clk);
        chk({tag, " mode_after_irq"}, ap_mode, 0);
        tick();
        got = 0; stall_cnt = 0; cyc = 0;
        while (got < v.len && cyc < v.len * 20 + 100) begin
            if (got == v.stall_word && stall_cnt < v.stall_len) mr = 1'b0;
            else mr = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready = mr;
            @(negedge clk);
            if (m_valid && !m_ready && got == v.stall_word) stall_cnt++;
            if (m_valid && m_ready) got++;
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        if (got < v.len) chk({tag, " out_words"}, got, v.len);
        repeat (3) tick();
        @(negedge clk);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " done_count"}, n_done, 1);
        chk({tag, " err_count"}, n_errlen + n_errt, 0);
        chk({tag, " write_count"}, q_wr.size(), 2 * v.len);
        for (int i = 0; i < 2 * v.len && i < q_wr.size(); i++) begin
            int k = i % v.len;
            int d = (i < v.len) ? a[k] : b[k];
            chk({tag, " write"}, q_wr[i], int'({(i < v.len) ? 2'd0 : 2'd1, AW'(k), 8'(d)}));
        end
        chk({tag, " read_count"}, q_rd.size(), v.len);
        for (int i = 0; i < v.len && i < q_rd.size(); i++)
            chk({tag, " read"}, q_rd[i], int'({2'd2, AW'(i)}));
        chk({tag, " result_count"}, q_m.size(), v.len);
        for (int i = 0; i < v.len && i < q_m.size(); i++)
            chk({tag, " result"}, q_m[i], (a[i] + b[i]) % 256);
        tick();
    endtask

    task automatic tmo_job(input logic tie, input string tag);
        int acc, cyc;
        t_start = 1'b1; t_len = AW'(1); t_cmd_in = 3'b011; t_dir_in = 1'b0;
        tick();
        t_start = 1'b0; t_s_valid = 1'b1; t_s_data = 8'd1;
        tick();
        tick();
        t_s_valid = 1'b0;
        @(negedge clk);
        chk({tag, " start_mode"}, t_ap_mode, 1);
        chk({tag, " start_cmd"}, t_ap_cmd, 3);
        tick();
        for (int k = 1; k <= 16; k++) begin
            t_irq = (tie && k == 16);
            @(negedge clk);
            chk({tag, " err_timeout"}, t_err_timeout, (!tie && k == 16) ? 1 : 0);
            tick();
        end
        t_irq = 1'b0;
        @(negedge clk);
        chk({tag, " mode_after"}, t_ap_mode, 0);
        chk({tag, " busy_after"}, t_busy, tie ? 1 : 0);
        if (tie) begin
            chk({tag, " read_en"}, t_ap_read_en, 1);
            chk({tag, " read_bank"}, t_ap_sel_col, 2);
            tick();
            t_m_ready = 1'b1;
            acc = 0; cyc = 0;
            while (acc == 0 && cyc < 10) begin
                @(negedge clk);
                if (t_m_valid) begin
                    acc = 1;
                    chk({tag, " m_data"}, t_m_data, 8'h5A);
                end
                tick();
                cyc++;
            end
            if (acc == 0) chk({tag, " m_valid_seen"}, 0, 1);
            t_m_ready = 1'b0;
            @(negedge clk);
            chk({tag, " done"}, t_done, 1);
        end else begin
            tick();
            @(negedge clk);
            chk({tag, " err_once"}, t_err_timeout, 0);
            chk({tag, " idle"}, t_busy, 0);
        end
        tick();
    endtask

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        tbl[0] = '{4,   3'b010, 1'b1, 20, 2,   5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{0,   3'b001, 1'b0, 1,  -1,  0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{513, 3'b001, 1'b0, 1,  -1,  0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1,   3'b111, 1'b0, 1,  0,   3, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{512, 3'b101, 1'b1, 3,  511, 4, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{2,   3'b011, 1'b1, 5,  -1,  0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; cmd_in = '0; dir_in = 1'b0; len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0; ap_state_irq = 1'b0;
        t_start = 1'b0; t_cmd_in = '0; t_dir_in = 1'b0; t_len = '0;
        t_s_valid = 1'b0; t_s_data = '0; t_m_ready = 1'b0; t_irq = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("reset outputs", int'({busy, done, err_len, err_timeout, s_ready, m_valid,
                                   ap_write_en, ap_read_en, ap_mode, ap_op_direction}), 0);
        chk("reset data", int'({m_data, ap_sel_col, ap_cmd}), 0);
        chk("reset tmo_inst", int'({t_busy, t_ap_mode, t_m_valid, t_s_ready}), 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_job(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of LOAD_B aborts silently
        n_done = 0; n_errlen = 0; n_errt = 0;
        start = 1'b1; len = AW'(3); cmd_in = 3'b001;
        tick();
        start = 1'b0; s_valid = 1'b1; s_data = 8'h33;
        repeat (4) tick();
        s_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst busy", busy, 0);
        chk("midrst write_en", ap_write_en, 0);
        chk("midrst mode", ap_mode, 0);
        chk("midrst s_ready", s_ready, 0);
        repeat (3) tick();
        chk("midrst no pulses", n_done + n_errlen + n_errt, 0);
        run_job(tbl[5], "after_reset");

        for (int r = 0; r < 6; r++) begin
            rv = '{int'($urandom_range(1, 40)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 30)), -1, 0, 1'b0, 1'b1, 1'b0};
            run_job(rv, $sformatf("rnd%0d", r));
        end

        tmo_job(1'b0, "timeout");
        tmo_job(1'b1, "irq_tie");

        chk("protocol invariants", n_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ap_job_sequencer.md
Name: ap_job_sequencer

Overview:
Sequences one complete associative-processor job on the AP array. It streams operand A into bank 0 and operand B into bank 1. It then issues the compute command and waits for the AP completion interrupt. Finally it streams the result words back out of the result bank. It sits between the host/DMA streaming logic and the AP core port group (addr, data, cmd, sel_col, sel_internal_col, ap_mode, op_direction, write_en, read_en, data_out, ap_state_irq).

Parameters:
WORD_SIZE, 8, AP word width in bits
CELL_QUANT, 512, number of AP cells (words per bank)
ADDR_W, clogb2(CELL_QUANT), cell address width (10 for 512)
RES_BANK, 2, sel_col value of the result bank
TIMEOUT_CYCLES, 65536, maximum cycles in WAIT_IRQ; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  job request, sampled only in IDLE
cmd_in  in  3  AP operation code for the job
dir_in  in  1  AP op_direction for the job
len  in  ADDR_W  number of cells in the job, legal range 1..CELL_QUANT
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse after the last result word is accepted
err_len  out  1  one-cycle pulse when start is rejected for an illegal len
err_timeout  out  1  one-cycle pulse when the AP fails to complete in time
s_valid  in  1  operand stream valid
s_ready  out  1  operand stream ready
s_data  in  WORD_SIZE  operand word
m_valid  out  1  result stream valid
m_ready  in  1  result stream ready
m_data  out  WORD_SIZE  result word
ap_addr  out  ADDR_W  AP cell address
ap_data  out  WORD_SIZE  AP write data
ap_cmd  out  3  AP command
ap_sel_col  out  2  AP bank select
ap_sel_internal_col  out  1  AP internal column select, tied to 0
ap_mode  out  1  AP compute enable
ap_op_direction  out  1  AP operation direction
ap_write_en  out  1  AP write strobe
ap_read_en  out  1  AP read strobe
ap_data_in  in  WORD_SIZE  AP read data (data_out of the AP)
ap_state_irq  in  1  AP completion indication

Behaviour:
- Reset: all outputs are 0, the state goes to IDLE, and the counters clear. Reset mid-job aborts the job with no done and no err pulse.
- Job latch: in IDLE, on start=1, cmd_in, dir_in and len are latched.
  - If len==0 or len>CELL_QUANT: pulse err_len and stay in IDLE.
  - Otherwise go to LOAD_A with idx=0.
- LOAD_A:
  - s_ready=1, ap_sel_col=0.
  - Each s_valid&&s_ready beat drives ap_write_en=1, ap_addr=idx and ap_data=s_data combinationally in the same cycle, then increments idx.
  - The beat with idx==len-1 clears idx and moves to LOAD_B.
- LOAD_B: same as LOAD_A with ap_sel_col=1. The last beat moves to START.
- Write/read exclusivity: ap_write_en and ap_read_en are never high together. ap_write_en is never high outside the LOAD states.
- START (1 cycle): ap_mode=1, ap_cmd=latched cmd, ap_op_direction=latched dir. Go to WAIT_IRQ and clear the timeout counter.
- WAIT_IRQ:
  - ap_mode, ap_cmd and ap_op_direction are held stable.
  - ap_state_irq==1 in a cycle: drop ap_mode next cycle and go to READ_REQ with idx=0.
  - Timeout: if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without irq, pulse err_timeout, drop ap_mode and go to IDLE.
  - An irq arriving in the same cycle as the timeout wins: no error is raised.
- READ_REQ (1 cycle): ap_read_en=1, ap_sel_col=RES_BANK, ap_addr=idx. Go to READ_WAIT.
- READ_WAIT (1 cycle, the AP read latency): capture ap_data_in into the output register. Go to OUT.
- OUT:
  - m_valid=1 and m_data is held stable until m_ready.
  - On m_ready: if idx==len-1, go to DONE; else increment idx and go to READ_REQ.
  - Throughput: at most one result word per 3 cycles.
- DONE (1 cycle): done=1, then IDLE.
- Ignored inputs:
  - s_valid is ignored outside the LOAD states.
  - start is ignored while busy.
- ap_sel_col in IDLE, START and WAIT_IRQ: holds its last value. ap_addr outside write/read cycles is don't-care.
- Widths: idx is ADDR_W bits. len==CELL_QUANT=512 needs 10 bits, so it fits; no wrap occurs because the compare uses len-1.

Test Plan:
- Reset mid-job: assert rst during LOAD_B -> next cycle busy=0, ap_write_en=0, ap_mode=0; a new start with len=2 completes normally.
- len=4, cmd=3'b010, dir=1, operands A=1..4 and B=10..13 -> ap_write_en pulses at addr 0..3 with sel_col=0, then 0..3 with sel_col=1. One START cycle then shows ap_mode=1, ap_cmd=2, ap_op_direction=1.
- Continuing that job, irq 20 cycles after START with the AP model returning 11,13,15,17 -> four reads at RES_BANK addr 0..3, m_data=11,13,15,17, done pulses once.
- m_ready held low for 5 cycles at word 2 -> m_valid stays high with m_data stable, and no extra ap_read_en is issued.
- start with len=0, then with len=513 -> err_len pulses each time, busy stays 0, and there is no AP activity.
- TIMEOUT_CYCLES=16 with irq never asserted -> err_timeout pulses 16 cycles after START, ap_mode drops, and the state returns to IDLE.
